// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage.
// Contents: opcode constants, ALU operation codes, the ID/EX control bundle
// (id_ex_ctrl_t) with its NOP value, and the operand-usage helpers used by the
// load-use hazard check.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    // alu_src_a: 0 = rs1, 1 = pc.  alu_src_b: 0 = rs2, 1 = imm.
    // result_src: 0 = ALU, 1 = memory, 2 = pc+4.  pc_target_src: 0 = pc+imm, 1 = rs1+imm.
    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] result_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_size;
        logic       mem_signed;
        logic       branch;
        logic       jump;
        logic       pc_target_src;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_NOP = '0;

    // Unknown opcodes decode as NOP, so they read no operands.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID, flush/stall, write-back and ID/EX signals of the decode stage.
// master: the surrounding pipeline (drives IF/ID, flush, ext_stall, WB).
// slave:  the decode stage (drives stall_req, ex_* and a0).
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
);
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [DATA_WIDTH-1:0] if_pc;
    logic                  flush;
    logic                  ext_stall;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  stall_req;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_rs1_data;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_WIDTH-1:0] ex_imm;
    id_ex_ctrl_t           ex_ctrl;
    logic [DATA_WIDTH-1:0] a0;

    modport master (
        output if_valid, if_instr, if_pc, flush, ext_stall, wb_we, wb_rd, wb_data,
        input  stall_req, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl, a0
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ext_stall, wb_we, wb_rd, wb_data,
        output stall_req, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl, a0
    );
endinterface

// File: rtl/control_unit.sv
// Main control decoder: maps opcode/funct3/funct7[5] to the ID/EX control
// bundle. Ports: opcode, funct3, funct7_5 in; ctrl out (CTRL_NOP for unknown
// opcodes).
module control_unit
    import decode_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output id_ex_ctrl_t ctrl
);
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OPC_OP: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_op(funct3, funct7_5);
            end
            OPC_OP_IMM: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                // funct7[5] only selects SRAI; ADDI has no subtract form.
                ctrl.alu_control = alu_op(funct3, funct3 == 3'b101 && funct7_5);
            end
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = 2'd1;
                ctrl.mem_size   = funct3[1:0];
                ctrl.mem_signed = ~funct3[2];
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.mem_size  = funct3[1:0];
            end
            OPC_BRANCH: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = (funct3[2:1] == 2'b10) ? ALU_SLT :
                                   (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = 2'd2;
            end
            OPC_JALR: begin
                ctrl.reg_write     = 1'b1;
                ctrl.jump          = 1'b1;
                ctrl.result_src    = 2'd2;
                ctrl.alu_src_b     = 1'b1;
                ctrl.pc_target_src = 1'b1;
            end
            OPC_LUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file with two read ports, one write port,
// write-first bypass and a tap of register A0_INDEX.
// Ports: clk, rst (sync, active-high, clears all registers), we/waddr/wdata
// (write port), raddr1/raddr2 -> rdata1/rdata2 (bypassed reads), a0 (stored
// value of register A0_INDEX, not bypassed).
module regfile_bypass #(
    parameter int  DATA_WIDTH = 32,
    parameter int  REG_COUNT  = 32,
    parameter int  A0_INDEX   = 10,
    localparam int REG_ADDR_W = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] a0
);
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    // x0 override comes last so a write-back aimed at x0 never leaks through the bypass.
    always_comb begin
        rdata1 = regs_q[raddr1];
        if (we && waddr == raddr1) rdata1 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        rdata2 = regs_q[raddr2];
        if (we && waddr == raddr2) rdata2 = wdata;
        if (raddr2 == '0) rdata2 = '0;
    end

    assign a0 = regs_q[A0_INDEX];
endmodule

// File: rtl/sign_extend.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate
// selected by the opcode. Ports: instr in, imm out (0 for formats without one).
module sign_extend
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: ;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: decodes IF/ID, reads bypassed operands,
// raises stall_req on a load-use hazard and holds the ID/EX register.
// Ports: clk, rst (sync, active-high), io (decode_stage_if.slave): IF/ID in,
// flush/ext_stall in, write-back in, stall_req/ex_*/a0 out.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int A0_INDEX   = 10
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave io
);
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    logic [31:0]           instr;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [31:0]           imm32;
    id_ex_ctrl_t           dec_ctrl;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
    logic                  stall_req;

    logic                  ex_valid_q, ex_valid_d;
    logic [DATA_WIDTH-1:0] ex_pc_q, ex_pc_d;
    logic [DATA_WIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [DATA_WIDTH-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [DATA_WIDTH-1:0] ex_imm_q, ex_imm_d;
    id_ex_ctrl_t           ex_ctrl_q, ex_ctrl_d;

    assign instr = io.if_instr[31:0];
    assign rs1   = instr[15 +: REG_ADDR_W];
    assign rs2   = instr[20 +: REG_ADDR_W];
    assign rd    = instr[7 +: REG_ADDR_W];

    control_unit u_ctrl (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .ctrl     (dec_ctrl)
    );

    sign_extend u_sext (
        .instr (instr),
        .imm   (imm32)
    );

    regfile_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .A0_INDEX   (A0_INDEX)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (io.wb_we),
        .waddr  (io.wb_rd),
        .wdata  (io.wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .a0     (io.a0)
    );

    // A load in EX whose destination feeds an operand this instruction actually reads.
    assign stall_req = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) && io.if_valid &&
                       ((uses_rs1(instr[6:0]) && ex_rd_q == rs1) ||
                        (uses_rs2(instr[6:0]) && ex_rd_q == rs2));

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_imm_d      = ex_imm_q;
        ex_ctrl_d     = ex_ctrl_q;
        if (io.flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NOP;
        end else if (io.ext_stall) begin
            // hold everything
        end else if (stall_req) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NOP;
        end else begin
            ex_valid_d    = io.if_valid;
            ex_pc_d       = io.if_pc;
            ex_rs1_data_d = rs1_data;
            ex_rs2_data_d = rs2_data;
            ex_rs1_d      = rs1;
            ex_rs2_d      = rs2;
            ex_rd_d       = rd;
            ex_imm_d      = DATA_WIDTH'($signed(imm32));
            ex_ctrl_d     = io.if_valid ? dec_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= CTRL_NOP;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
        end
    end

    assign io.stall_req   = stall_req;
    assign io.ex_valid    = ex_valid_q;
    assign io.ex_pc       = ex_pc_q;
    assign io.ex_rs1_data = ex_rs1_data_q;
    assign io.ex_rs2_data = ex_rs2_data_q;
    assign io.ex_rs1      = ex_rs1_q;
    assign io.ex_rs2      = ex_rs2_q;
    assign io.ex_rd       = ex_rd_q;
    assign io.ex_imm      = ex_imm_q;
    assign io.ex_ctrl     = ex_ctrl_q;
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage;

    logic clk;
    logic rst;

    decode_stage_if #(.DATA_WIDTH(32), .REG_COUNT(32)) io ();

    decode_stage #(.DATA_WIDTH(32), .REG_COUNT(32), .A0_INDEX(10)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        rw, mr, mw, br, jp, u1, u2;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t dec(input logic [31:0] ins);
        dec_t d;
        logic [31:0] i_imm;
        d = '0;
        i_imm = 32'($signed(ins) >>> 20);
        case (ins[6:0])
            7'h37: begin d.rw = 1; d.imm = ins & 32'hFFFF_F000; end                    // LUI
            7'h17: begin d.rw = 1; d.imm = ins & 32'hFFFF_F000; end                    // AUIPC
            7'h6F: begin d.rw = 1; d.jp = 1;
                         d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            7'h67: begin d.rw = 1; d.jp = 1; d.u1 = 1; d.imm = i_imm; end              // JALR
            7'h63: begin d.br = 1; d.u1 = 1; d.u2 = 1;
                         d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'h03: begin d.rw = 1; d.mr = 1; d.u1 = 1; d.imm = i_imm; end              // LOAD
            7'h23: begin d.mw = 1; d.u1 = 1; d.u2 = 1;
                         d.imm = (i_imm & ~32'h1F) | 32'(ins[11:7]); end               // STORE
            7'h13: begin d.rw = 1; d.u1 = 1; d.imm = i_imm; end                        // OP-IMM
            7'h33: begin d.rw = 1; d.u1 = 1; d.u2 = 1; end                             // OP
            default: ;
        endcase
        return d;
    endfunction

    logic [31:0] ref_rf [32];
    logic        m_valid, m_rw, m_mr, m_mw, m_br, m_jp;
    logic [31:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    dec_t        md;

    function automatic logic [31:0] rd_ref(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (io.wb_we && io.wb_rd == r) return io.wb_data;
        return ref_rf[r];
    endfunction

    function automatic logic exp_hazard();
        dec_t d;
        d = dec(io.if_instr);
        return m_valid && m_mr && m_rd != 0 && io.if_valid &&
               ((d.u1 && m_rd == io.if_instr[19:15]) || (d.u2 && m_rd == io.if_instr[24:20]));
    endfunction

    task automatic m_kill();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_jp = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_kill();
            m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
        end else begin
            if (io.flush) m_kill();
            else if (io.ext_stall) ;
            else if (exp_hazard()) m_kill();
            else begin
                md      = dec(io.if_instr);
                m_valid = io.if_valid;
                m_pc    = io.if_pc;
                m_rs1   = io.if_instr[19:15];
                m_rs2   = io.if_instr[24:20];
                m_rd    = io.if_instr[11:7];
                m_imm   = md.imm;
                m_d1    = rd_ref(m_rs1);
                m_d2    = rd_ref(m_rs2);
                m_rw = io.if_valid & md.rw; m_mr = io.if_valid & md.mr;
                m_mw = io.if_valid & md.mw; m_br = io.if_valid & md.br;
                m_jp = io.if_valid & md.jp;
            end
            if (io.wb_we && io.wb_rd != 0) ref_rf[io.wb_rd] = io.wb_data;
        end
    end

    // Single compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_req", io.stall_req, exp_hazard());
            chk("a0", io.a0, ref_rf[10]);
            chk("ex_valid", io.ex_valid, m_valid);
            chk("reg_write", io.ex_ctrl.reg_write, m_rw);
            chk("mem_write", io.ex_ctrl.mem_write, m_mw);
            chk("mem_read", io.ex_ctrl.mem_read, m_mr);
            if (!m_valid) chk("ctrl_nop", io.ex_ctrl, 0);
            else begin
                chk("ex_pc", io.ex_pc, m_pc);
                chk("ex_rs1", io.ex_rs1, m_rs1);
                chk("ex_rs2", io.ex_rs2, m_rs2);
                chk("ex_rd", io.ex_rd, m_rd);
                chk("ex_imm", io.ex_imm, m_imm);
                chk("ex_rs1_data", io.ex_rs1_data, m_d1);
                chk("ex_rs2_data", io.ex_rs2_data, m_d2);
                chk("branch", io.ex_ctrl.branch, m_br);
                chk("jump", io.ex_ctrl.jump, m_jp);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        io.if_valid = 1'b1;
        io.if_instr = ins;
        io.if_pc    = pc;
    endtask

    logic [6:0]  opc_list [11];
    logic [31:0] ins;
    logic [31:0] lw_x6, add_dep, add_byp, add_x0, addi_x5;

    initial begin
        opc_list = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h03, 7'h7F};
        addi_x5 = enc_i(7'h13, 3'b000, 5, 0, 7);
        add_byp = enc_r(1, 3, 3);
        add_x0  = enc_r(1, 0, 0);
        lw_x6   = enc_i(7'h03, 3'b010, 6, 2, 0);
        add_dep = enc_r(7, 6, 1);

        rst = 1'b1;
        io.if_valid = 0; io.if_instr = 0; io.if_pc = 0;
        io.flush = 0; io.ext_stall = 0;
        io.wb_we = 0; io.wb_rd = 0; io.wb_data = 0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_ex_valid", io.ex_valid, 0);
        chk("rst_ex_pc", io.ex_pc, 0);
        chk("rst_ex_imm", io.ex_imm, 0);
        chk("rst_ex_ctrl", io.ex_ctrl, 0);
        chk("rst_a0", io.a0, 0);
        rst = 1'b0;

        // ADDI x5,x0,7 at 0x10
        present(addi_x5, 32'h10);
        step();
        chk("addi_valid", io.ex_valid, 1);
        chk("addi_pc", io.ex_pc, 32'h10);
        chk("addi_rd", io.ex_rd, 5);
        chk("addi_imm", io.ex_imm, 7);
        chk("addi_reg_write", io.ex_ctrl.reg_write, 1);
        chk("addi_rs1_data", io.ex_rs1_data, 0);

        // write-back bypass
        present(add_byp, 32'h14);
        io.wb_we = 1; io.wb_rd = 3; io.wb_data = 32'hDEADBEEF;
        step();
        chk("byp_rs1_data", io.ex_rs1_data, 32'hDEADBEEF);
        chk("byp_rs2_data", io.ex_rs2_data, 32'hDEADBEEF);
        present(add_x0, 32'h18);
        io.wb_rd = 0; io.wb_data = 32'h1234;
        step();
        chk("byp_x0_rs1", io.ex_rs1_data, 0);
        chk("byp_x0_rs2", io.ex_rs2_data, 0);
        io.wb_we = 0;

        // load-use hazard
        present(lw_x6, 32'h20);
        step();
        chk("lw_mem_read", io.ex_ctrl.mem_read, 1);
        present(add_dep, 32'h24);
        @(negedge clk);
        chk("lu_stall", io.stall_req, 1);
        step();
        chk("lu_bubble_valid", io.ex_valid, 0);
        chk("lu_bubble_rw", io.ex_ctrl.reg_write, 0);
        @(negedge clk);
        chk("lu_stall_clear", io.stall_req, 0);
        step();
        chk("lu_add_valid", io.ex_valid, 1);
        chk("lu_add_rd", io.ex_rd, 7);
        present(lw_x6, 32'h28);
        step();
        present({20'h12345, 5'd6, 7'h37}, 32'h2C);
        @(negedge clk);
        chk("lui_no_stall", io.stall_req, 0);
        step();
        chk("lui_valid", io.ex_valid, 1);

        // flush beats ext_stall
        present(add_byp, 32'h30);
        io.flush = 1; io.ext_stall = 1;
        step();
        chk("flush_valid", io.ex_valid, 0);
        io.flush = 0; io.ext_stall = 0;

        // ext_stall holds ID/EX for 3 cycles
        present(addi_x5, 32'h40);
        step();
        present(add_byp, 32'h44);
        io.ext_stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", io.ex_valid, 1);
            chk("hold_pc", io.ex_pc, 32'h40);
            chk("hold_rd", io.ex_rd, 5);
            chk("hold_imm", io.ex_imm, 7);
        end
        io.ext_stall = 0;

        // a0 tap and x0 write
        io.if_valid = 0;
        io.wb_we = 1; io.wb_rd = 10; io.wb_data = 32'h55;
        @(negedge clk);
        chk("a0_before", io.a0, 0);
        step();
        chk("a0_after", io.a0, 32'h55);
        io.wb_rd = 0; io.wb_data = 32'h99;
        step();
        io.wb_we = 0;
        present(add_x0, 32'h50);
        step();
        chk("x0_read", io.ex_rs1_data, 0);

        // reset during a load-use stall with a pending write-back
        present(lw_x6, 32'h60);
        step();
        present(add_dep, 32'h64);
        io.wb_we = 1; io.wb_rd = 12; io.wb_data = 32'hAA;
        rst = 1;
        @(negedge clk);
        chk("rst_mid_stall", io.stall_req, 1);
        step();
        rst = 0; io.wb_we = 0;
        chk("rstm_valid", io.ex_valid, 0);
        chk("rstm_pc", io.ex_pc, 0);
        chk("rstm_rd", io.ex_rd, 0);
        chk("rstm_ctrl", io.ex_ctrl, 0);
        chk("rstm_a0", io.a0, 0);
        present(enc_r(1, 12, 12), 32'h68);
        step();
        chk("rstm_x12_rs1", io.ex_rs1_data, 0);
        chk("rstm_x12_rs2", io.ex_rs2_data, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ins        = $urandom();
            ins[6:0]   = opc_list[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            io.if_valid  = ($urandom_range(0, 9) < 8);
            io.if_instr  = ins;
            io.if_pc     = $urandom();
            io.flush     = ($urandom_range(0, 9) == 0);
            io.ext_stall = ($urandom_range(0, 6) == 0);
            io.wb_we     = 1'($urandom_range(0, 1));
            io.wb_rd     = 5'($urandom_range(0, 15));
            io.wb_data   = $urandom();
            rst          = ($urandom_range(0, 99) == 0);
            step();
        end

        rst = 0; io.if_valid = 0; io.flush = 0; io.ext_stall = 0; io.wb_we = 0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
